// File: rtl/block_memory.sv
// rtl/block_memory.sv - block-granular main memory with configurable beats and access latency
module block_memory #(
  parameter int ADDR_WIDTH     = 28,
  parameter int BLOCK_BYTES    = 16,
  parameter int BEAT_BYTES     = 4,
  parameter int MEM_BLOCKS     = 64,
  parameter int ACCESS_LATENCY = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [ADDR_WIDTH-1:0]    i_address,
  input  logic [BLOCK_BYTES*8-1:0] i_writedata,
  output logic [BLOCK_BYTES*8-1:0] o_readdata,
  output logic                     o_busywait,
  output logic                     o_error
);

  localparam int BEATS     = BLOCK_BYTES / BEAT_BYTES;
  localparam int BEAT_BITS = BEAT_BYTES * 8;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W     = (ACCESS_LATENCY > 0) ? $clog2(ACCESS_LATENCY + 1) : 1;
  localparam int MEM_AW    = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
  localparam int AW1       = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TRANSFER, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [BEAT_W-1:0]                 r_beat;
  logic [LAT_W-1:0]                  r_lat;
  logic                              r_is_write;
  logic [ADDR_WIDTH-1:0]             r_addr;
  logic [BEATS-1:0][BEAT_BITS-1:0]   r_wdata;
  logic [BEATS-1:0][BEAT_BITS-1:0]   r_rdata;
  logic                              r_error;
  logic [BEATS-1:0][BEAT_BITS-1:0]   r_mem [MEM_BLOCKS];

  logic              w_req;
  logic              w_illegal;
  logic              w_accept;
  logic              w_in_range;
  logic              w_last_beat;
  logic              w_lat_done;
  logic              w_beat_go;
  logic [MEM_AW-1:0] w_idx;

  assign w_req       = i_read | i_write;
  assign w_illegal   = i_read & i_write & (r_state == S_IDLE);
  assign w_accept    = (r_state == S_IDLE) & (i_read ^ i_write);
  // One extra bit so MEM_BLOCKS == 2**ADDR_WIDTH still compares correctly
  assign w_in_range  = ({1'b0, r_addr} < AW1'(MEM_BLOCKS));
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_lat_done  = (r_lat == LAT_W'(ACCESS_LATENCY - 1));
  // A beat only moves while the cache still holds its request
  assign w_beat_go   = (r_state == S_TRANSFER) & w_req;
  assign w_idx       = r_addr[MEM_AW-1:0];
  assign o_readdata  = r_rdata;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (ACCESS_LATENCY > 0) ? S_WAIT : S_TRANSFER;
      end
      S_WAIT: begin
        if (!w_req)          w_next = S_IDLE;
        else if (w_lat_done) w_next = S_TRANSFER;
      end
      S_TRANSFER: begin
        if (!w_req)           w_next = S_IDLE;
        else if (w_last_beat) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busywait = w_req & ~w_illegal & (r_state != S_DONE);
    o_error    = r_error | w_illegal;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lat      <= '0;
      r_beat     <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_write <= i_write;
            r_addr     <= i_address;
            r_wdata    <= i_writedata;
            r_lat      <= '0;
            r_beat     <= '0;
            r_error    <= 1'b0;
            if (i_read) r_rdata <= '0;
          end
        end
        S_WAIT: r_lat <= r_lat + 1'b1;
        S_TRANSFER: begin
          if (w_req) begin
            r_beat <= r_beat + 1'b1;
            if (!r_is_write && w_in_range) r_rdata[r_beat] <= r_mem[w_idx][r_beat];
            if (w_last_beat && !w_in_range) r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately outside the reset domain: committed beats survive reset
  always_ff @(posedge i_clock) begin
    if (w_beat_go && r_is_write && w_in_range) r_mem[w_idx][r_beat] <= r_wdata[r_beat];
  end

endmodule

// File: tb/tb_block_memory.sv
// tb/tb_block_memory.sv - self-checking bench for block_memory
module tb_block_memory;

  localparam int AW = 28;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd, wr, rd_l0, rd_b1, wr_sub;
  logic [AW-1:0] addr;
  logic [127:0] wdata;
  logic [127:0] rdata, rdata_l0, rdata_b1;
  logic         busy, err, busy_l0, err_l0, busy_b1, err_b1;

  always #5 clk = ~clk;

  block_memory dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_read(rd), .i_write(wr),
    .i_address(addr), .i_writedata(wdata),
    .o_readdata(rdata), .o_busywait(busy), .o_error(err)
  );

  block_memory #(.BEAT_BYTES(16), .ACCESS_LATENCY(0)) dut_l0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_read(rd_l0), .i_write(wr_sub),
    .i_address(addr), .i_writedata(wdata),
    .o_readdata(rdata_l0), .o_busywait(busy_l0), .o_error(err_l0)
  );

  block_memory #(.BEAT_BYTES(1), .ACCESS_LATENCY(0)) dut_b1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_read(rd_b1), .i_write(wr_sub),
    .i_address(addr), .i_writedata(wdata),
    .o_readdata(rdata_b1), .o_busywait(busy_b1), .o_error(err_b1)
  );

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [127:0]  data;
    int            exp_busy;
    logic          chk_rd;
    logic [127:0]  exp_rd;
    logic          exp_err;
  } vec_t;

  typedef struct {
    int           busy;
    logic         chk_rd;
    logic [127:0] rd;
    logic         err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [127:0] data_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [127:0] pat0   = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
  logic [127:0] pat1   = 128'hCAFEBABE_DEADBEEF_01020304_05060708;
  logic [127:0] pat3   = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int b, input logic c, input logic [127:0] r, input logic e);
    exp_t x;
    x.busy = b; x.chk_rd = c; x.rd = r; x.err = e;
    sb.push_back(x);
  endtask

  // Drives one request from IDLE, counts busy cycles, compares against the scoreboard in DONE
  task automatic run_access(input logic is_wr, input logic [AW-1:0] a, input logic [127:0] d,
                            input string name);
    int   cnt;
    exp_t e;
    @(negedge clk);
    rd = !is_wr; wr = is_wr; addr = a; wdata = d;
    #1;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(posedge clk); #2;
    end
    e = sb.pop_front();
    check({name, " busy"}, 128'(cnt), 128'(e.busy));
    if (e.chk_rd) check({name, " rdata"}, rdata, e.rd);
    check({name, " error"}, {127'd0, err}, {127'd0, e.err});
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic set_vec(input int i, input logic w, input logic [AW-1:0] a, input logic [127:0] d,
                         input logic c, input logic [127:0] r, input logic e);
    vecs[i].is_wr = w; vecs[i].addr = a; vecs[i].data = d; vecs[i].exp_busy = 8;
    vecs[i].chk_rd = c; vecs[i].exp_rd = r; vecs[i].exp_err = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    set_vec(0,  1'b1, 28'd5,         data_a,  1'b0, '0,     1'b0);
    set_vec(1,  1'b0, 28'd5,         '0,      1'b1, data_a, 1'b0);
    set_vec(2,  1'b1, 28'd0,         pat0,    1'b0, '0,     1'b0);
    set_vec(3,  1'b0, 28'd64,        '0,      1'b1, '0,     1'b1);
    set_vec(4,  1'b1, 28'd64,        pat3,    1'b0, '0,     1'b1);
    set_vec(5,  1'b0, 28'd0,         '0,      1'b1, pat0,   1'b0);
    set_vec(6,  1'b1, 28'd63,        pat1,    1'b0, '0,     1'b0);
    set_vec(7,  1'b0, 28'd63,        '0,      1'b1, pat1,   1'b0);
    set_vec(8,  1'b0, 28'hFFFFFFF,   '0,      1'b1, '0,     1'b1);
    set_vec(9,  1'b1, 28'd2,         '0,      1'b0, '0,     1'b0);
    set_vec(10, 1'b0, 28'd5,         '0,      1'b1, data_a, 1'b0);

    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; rd_l0 = 1'b0; rd_b1 = 1'b0; wr_sub = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset rdata", rdata, '0);
    check("reset error", {127'd0, err}, 128'd0);
    check("reset busy", {127'd0, busy}, 128'd0);
    rd = 1'b1; #1;
    check("idle busy read only", {127'd0, busy}, 128'd1);
    wr = 1'b1; #1;
    check("idle busy both", {127'd0, busy}, 128'd0);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;

    foreach (vecs[i]) begin
      push_exp(vecs[i].exp_busy, vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_err);
      run_access(vecs[i].is_wr, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d error held", i), {127'd0, err}, {127'd0, vecs[i].exp_err});
    end

    // Illegal request: never accepted, error only while it persists
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 28'd5; wdata = pat3;
    #1;
    check("illegal busy", {127'd0, busy}, 128'd0);
    check("illegal error", {127'd0, err}, 128'd1);
    repeat (3) @(posedge clk);
    #2;
    check("illegal busy held", {127'd0, busy}, 128'd0);
    check("illegal error held", {127'd0, err}, 128'd1);
    check("illegal rdata held", rdata, data_a);
    rd = 1'b0; wr = 1'b0; #1;
    check("illegal error clears", {127'd0, err}, 128'd0);
    @(posedge clk); #2;
    push_exp(8, 1'b1, data_a, 1'b0);
    run_access(1'b0, 28'd5, '0, "after illegal");

    // Partial write: drop after two committed beats
    @(negedge clk);
    wr = 1'b1; addr = 28'd2; wdata = '1;
    repeat (6) @(posedge clk);
    #2;
    check("abort busy in transfer", {127'd0, busy}, 128'd1);
    wr = 1'b0;
    @(posedge clk); #2;
    check("abort error", {127'd0, err}, 128'd0);
    push_exp(8, 1'b1, {64'h0, 64'hFFFFFFFF_FFFFFFFF}, 1'b0);
    run_access(1'b0, 28'd2, '0, "partial write");

    // Reset in the middle of a read transfer
    @(negedge clk);
    rd = 1'b1; addr = 28'd5;
    repeat (6) @(posedge clk);
    #2;
    check("mid read partial", rdata, {64'h0, data_a[63:0]});
    rst_n = 1'b0; #1;
    check("reset mid rdata", rdata, '0);
    check("reset mid error", {127'd0, err}, 128'd0);
    rd = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    push_exp(8, 1'b1, data_a, 1'b0);
    run_access(1'b0, 28'd5, '0, "reissue after reset");

    // Alternate geometries: single wide beat and byte-wide beats, zero latency
    @(negedge clk);
    addr = 28'd3; rd_l0 = 1'b1;
    #1;
    cnt = 0;
    while (busy_l0 && cnt < 100) begin cnt++; @(posedge clk); #2; end
    check("l0 wide busy", 128'(cnt), 128'd2);
    check("l0 wide error", {127'd0, err_l0}, 128'd0);
    rd_l0 = 1'b0;
    @(posedge clk); #2;

    @(negedge clk);
    rd_b1 = 1'b1;
    #1;
    cnt = 0;
    while (busy_b1 && cnt < 100) begin cnt++; @(posedge clk); #2; end
    check("l0 byte busy", 128'(cnt), 128'd17);
    check("l0 byte error", {127'd0, err_b1}, 128'd0);
    rd_b1 = 1'b0;
    @(posedge clk); #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
